// File: rtl/xilinx_pclk_rate_ctrl_if.sv
// Handshake/status bundle between the PIPE clock rate sequencer and its controller.
// The controller drives the request side (master); the sequencer owns the mux controls (slave).
interface xilinx_pclk_rate_ctrl_if #(
  parameter int PCIE_LANE = 2,
  parameter int NUM_RATES = 3
);
  logic                   mmcm_lock_i;
  logic [2*PCIE_LANE-1:0] rate_req_i;
  logic                   en_i;
  logic                   err_clr_i;
  logic [1:0]             pclk_sel_o;
  logic [NUM_RATES-1:0]   pclk_ce_o;
  logic [1:0]             cur_rate_o;
  logic                   rate_done_o;
  logic                   pclk_ready_o;
  logic                   busy_o;
  logic                   err_timeout_o;
  logic                   err_lock_lost_o;

  modport master (
    output mmcm_lock_i, rate_req_i, en_i, err_clr_i,
    input  pclk_sel_o, pclk_ce_o, cur_rate_o, rate_done_o, pclk_ready_o,
           busy_o, err_timeout_o, err_lock_lost_o
  );

  modport slave (
    input  mmcm_lock_i, rate_req_i, en_i, err_clr_i,
    output pclk_sel_o, pclk_ce_o, cur_rate_o, rate_done_o, pclk_ready_o,
           busy_o, err_timeout_o, err_lock_lost_o
  );
endinterface

// File: rtl/xilinx_pclk_rate_ctrl.sv
// Glitch-free PIPE clock rate sequencer: gate, select, ungate, acknowledge, on the control clock.
// Runs only while the filtered MMCM lock holds; reports lock-wait timeout and lock loss.
module xilinx_pclk_rate_ctrl #(
  parameter int PCIE_LANE    = 2,
  parameter int NUM_RATES    = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int SWITCH_GAP   = 8,
  parameter int LOCK_FILTER  = 16,
  parameter int LOCK_TIMEOUT = 1023
) (
  input logic clk_i,
  input logic rst_i,
  xilinx_pclk_rate_ctrl_if.slave bus
);

  localparam int LF_W = $clog2(LOCK_FILTER + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [LF_W-1:0] LF_MAX   = LF_W'(LOCK_FILTER);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(LOCK_TIMEOUT);
  localparam logic [7:0]      GAP_LAST = 8'(SWITCH_GAP - 1);
  localparam logic [2:0]      NR       = 3'(NUM_RATES);

  typedef enum logic [2:0] {WAIT_LOCK, RUN, GATE, SWITCH, UNGATE, DONE} state_t;

  function automatic logic [NUM_RATES-1:0] onehot(input logic [1:0] r);
    logic [NUM_RATES-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_RATES; k++)
      if (r == 2'(k)) v[k] = 1'b1;
    return v;
  endfunction

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [2*PCIE_LANE-1:0] req_sync [SYNC_STAGES];
  logic [2*PCIE_LANE-1:0] req_s, req_prev;
  logic                   lock_s, lock_ok, lanes_eq, req_valid;
  logic [1:0]             req_rate;
  logic [LF_W-1:0]        filt_cnt;

  state_t               state, state_nxt;
  logic [7:0]           gap_cnt, gap_nxt;
  logic [TO_W-1:0]      to_cnt, to_nxt;
  logic [1:0]           tgt, tgt_nxt, cur_rate, rate_nxt;
  logic                 done_flag, done_flag_nxt, to_set, lost_set;
  logic [NUM_RATES-1:0] ce_q, ce_nxt;
  logic                 done_q, ready_q, busy_q, err_to_q, err_ll_q;

  // Synchroniser stage: every asynchronous input bit passes SYNC_STAGES flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_sync <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) req_sync[s] <= '0;
      req_prev  <= '0;
      filt_cnt  <= '0;
    end else begin
      lock_sync   <= {lock_sync[SYNC_STAGES-2:0], bus.mmcm_lock_i};
      req_sync[0] <= bus.rate_req_i;
      for (int s = 1; s < SYNC_STAGES; s++) req_sync[s] <= req_sync[s-1];
      req_prev <= req_s;
      if (!lock_s)                filt_cnt <= '0;
      else if (filt_cnt != LF_MAX) filt_cnt <= filt_cnt + LF_W'(1);
    end
  end

  assign lock_s   = lock_sync[SYNC_STAGES-1];
  assign req_s    = req_sync[SYNC_STAGES-1];
  assign lock_ok  = lock_s && (filt_cnt == LF_MAX);
  assign req_rate = req_s[1:0];

  // A request counts only when every lane agrees, it held for a cycle, and the code exists
  always_comb begin
    lanes_eq = 1'b1;
    for (int n = 1; n < PCIE_LANE; n++)
      if (req_s[2*n +: 2] != req_s[1:0]) lanes_eq = 1'b0;
  end

  assign req_valid = lanes_eq && (req_s == req_prev) && ({1'b0, req_rate} < NR);

  always_comb begin
    state_nxt     = state;
    gap_nxt       = gap_cnt;
    to_nxt        = to_cnt;
    tgt_nxt       = tgt;
    done_flag_nxt = done_flag;
    rate_nxt      = cur_rate;
    lost_set      = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_ok) begin
          to_nxt        = '0;
          gap_nxt       = '0;
          done_flag_nxt = 1'b0;
          state_nxt     = UNGATE;
        end else if (to_cnt != TO_MAX) begin
          to_nxt = to_cnt + TO_W'(1);
        end
      end
      RUN: begin
        if (req_valid && (req_rate != cur_rate)) begin
          tgt_nxt       = req_rate;
          done_flag_nxt = 1'b1;
          gap_nxt       = '0;
          state_nxt     = GATE;
        end
      end
      GATE: begin
        // Commit on entry to SWITCH so the new select is visible in its first cycle
        if (gap_cnt == GAP_LAST) begin
          rate_nxt  = tgt;
          state_nxt = SWITCH;
        end else begin
          gap_nxt = gap_cnt + 8'd1;
        end
      end
      SWITCH: begin
        gap_nxt   = '0;
        state_nxt = UNGATE;
      end
      UNGATE: begin
        if (gap_cnt == GAP_LAST) state_nxt = done_flag ? DONE : RUN;
        else                     gap_nxt   = gap_cnt + 8'd1;
      end
      DONE: begin
        done_flag_nxt = 1'b0;
        state_nxt     = RUN;
      end
      default: state_nxt = WAIT_LOCK;
    endcase

    // Lock loss abandons any switch that has not yet committed its rate
    if ((state != WAIT_LOCK) && !lock_ok) begin
      state_nxt     = WAIT_LOCK;
      rate_nxt      = cur_rate;
      gap_nxt       = '0;
      done_flag_nxt = 1'b0;
      lost_set      = 1'b1;
    end

    to_set = (state == WAIT_LOCK) && !lock_ok && (to_nxt == TO_MAX);
    ce_nxt = '0;
    if ((state_nxt == RUN) || (state_nxt == UNGATE) || (state_nxt == DONE))
      ce_nxt = onehot(rate_nxt) & {NUM_RATES{bus.en_i}};
  end

  // Output stage: Moore outputs registered from the next state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= WAIT_LOCK;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      tgt       <= '0;
      done_flag <= 1'b0;
      cur_rate  <= '0;
      ce_q      <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      err_to_q  <= 1'b0;
      err_ll_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_nxt;
      to_cnt    <= to_nxt;
      tgt       <= tgt_nxt;
      done_flag <= done_flag_nxt;
      cur_rate  <= rate_nxt;
      ce_q      <= ce_nxt;
      done_q    <= (state_nxt == DONE);
      ready_q   <= (state_nxt == RUN);
      busy_q    <= (state_nxt != RUN);
      err_to_q  <= to_set   | (err_to_q & ~bus.err_clr_i);
      err_ll_q  <= lost_set | (err_ll_q & ~bus.err_clr_i);
    end
  end

  assign bus.pclk_sel_o      = cur_rate;
  assign bus.cur_rate_o      = cur_rate;
  assign bus.pclk_ce_o       = ce_q;
  assign bus.rate_done_o     = done_q;
  assign bus.pclk_ready_o    = ready_q;
  assign bus.busy_o          = busy_q;
  assign bus.err_timeout_o   = err_to_q;
  assign bus.err_lock_lost_o = err_ll_q;

endmodule
